hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RV64I core. It combines E-stage operand forwarding with load-use and RAW stall generation, and adds branch-redirect flushing. It also freezes the pipeline on a multi-cycle data-memory handshake, with wait-timeout detection and saturating stall/flush performance counters. It sits beside the datapath and drives the enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers plus the E-stage forwarding muxes.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E-stage forwarding, load-use / RAW bubbles, branch-redirect flush,
// data-memory freeze with wait-timeout detection, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned FWD_EN      = 1,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned WAIT_W      = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_rs1_d,
   input  logic [REG_AW-1:0] i_rs2_d,
   input  logic [REG_AW-1:0] i_rs1_e,
   input  logic [REG_AW-1:0] i_rs2_e,
   input  logic [REG_AW-1:0] i_rd_e,
   input  logic              i_reg_write_e,
   input  logic              i_mem_read_e,
   input  logic              i_pc_src_e,
   input  logic [REG_AW-1:0] i_rd_m,
   input  logic              i_reg_write_m,
   input  logic              i_dmem_req_m,
   input  logic              i_dmem_ready_m,
   input  logic [REG_AW-1:0] i_rd_w,
   input  logic              i_reg_write_w,
   output logic [1:0]        o_forward_a_e,
   output logic [1:0]        o_forward_b_e,
   output logic              o_stall_f,
   output logic              o_stall_d,
   output logic              o_stall_e,
   output logic              o_stall_m,
   output logic              o_stall_w,
   output logic              o_flush_d,
   output logic              o_flush_e,
   output logic              o_mem_timeout,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   typedef enum logic [0:0] {StRun, StWait} state_t;

   state_t            r_state, w_state_nxt;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic w_frz, w_redirect, w_e_hit, w_m_hit, w_lu, w_raw, w_bubble;

   // Register x0 is hard-wired, so it never creates a dependency.
   function automatic logic f_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   assign w_frz      = i_dmem_req_m & ~i_dmem_ready_m;
   assign w_redirect = i_pc_src_e & ~w_frz;
   assign w_e_hit    = f_hit(i_rd_e, i_rs1_d) | f_hit(i_rd_e, i_rs2_d);
   assign w_m_hit    = f_hit(i_rd_m, i_rs1_d) | f_hit(i_rd_m, i_rs2_d);
   assign w_lu       = (FWD_EN != 0) & i_mem_read_e & i_reg_write_e & w_e_hit;
   // Without forwarding, W needs no check because the regfile writes through.
   assign w_raw      = (FWD_EN == 0) & ((i_reg_write_e & w_e_hit) | (i_reg_write_m & w_m_hit));
   assign w_bubble   = w_lu | w_raw;

   // Forwarding mux selects; M result has priority over W as it is younger.
   always_comb begin
      o_forward_a_e = 2'b00;
      o_forward_b_e = 2'b00;
      if (!rst && (FWD_EN != 0)) begin
         if (i_reg_write_m && f_hit(i_rs1_e, i_rd_m))      o_forward_a_e = 2'b10;
         else if (i_reg_write_w && f_hit(i_rs1_e, i_rd_w)) o_forward_a_e = 2'b01;
         if (i_reg_write_m && f_hit(i_rs2_e, i_rd_m))      o_forward_b_e = 2'b10;
         else if (i_reg_write_w && f_hit(i_rs2_e, i_rd_w)) o_forward_b_e = 2'b01;
      end
   end

   // Stall/flush decode with priority freeze > redirect > bubble.
   always_comb begin
      o_stall_f = 1'b0;
      o_stall_d = 1'b0;
      o_stall_e = 1'b0;
      o_stall_m = 1'b0;
      o_stall_w = 1'b0;
      o_flush_d = 1'b0;
      o_flush_e = 1'b0;
      if (!rst) begin
         if (w_frz) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
            o_stall_w = 1'b1;
         end else if (w_redirect) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
         end else if (w_bubble) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
         end
      end
   end

   // Next state and wait count; the count equals consecutive frozen edges so far.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = '0;
      unique case (r_state)
         StRun: begin
            if (w_frz) begin
               w_state_nxt = StWait;
               w_wait_nxt  = WAIT_W'(1);
            end
         end
         StWait: begin
            if (w_frz) begin
               w_wait_nxt = (r_wait == '1) ? r_wait : r_wait + WAIT_W'(1);
            end else begin
               w_state_nxt = StRun;
            end
         end
         default: w_state_nxt = StRun;
      endcase
   end

   // FSM state, wait counter and sticky timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StRun;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         if (w_frz && (w_wait_nxt == WAIT_W'(MEM_TIMEOUT))) r_timeout <= 1'b1;
      end
   end

   // Saturating performance counters; lu/raw bubbles are not counted as flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (o_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_mem_timeout = r_timeout;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against two hazard_ctrl instances
// (A: forwarding, MEM_TIMEOUT=4, CNT_W=4; B: no forwarding, MEM_TIMEOUT=15, CNT_W=8).
module tb_hazard_ctrl;

   logic clk, rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic rwe, mre, pcsrc, rwm, req, rdy, rww;

   logic [1:0] a_fa, a_fb, b_fa, b_fb;
   logic [4:0] a_st, b_st;
   logic [1:0] a_fl, b_fl;
   logic       a_tmo, b_tmo;
   logic [3:0] a_sc, a_fc;
   logic [7:0] b_sc, b_fc;

   int n_checks = 0;
   int n_err    = 0;

   int scnt[2], fcnt[2], frun[2];
   bit tmo[2];
   int mt[2]   = '{4, 15};
   int cmax[2] = '{15, 255};

   hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .WAIT_W(4), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst),
      .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e), .i_rd_e(rd_e),
      .i_reg_write_e(rwe), .i_mem_read_e(mre), .i_pc_src_e(pcsrc),
      .i_rd_m(rd_m), .i_reg_write_m(rwm), .i_dmem_req_m(req), .i_dmem_ready_m(rdy),
      .i_rd_w(rd_w), .i_reg_write_w(rww),
      .o_forward_a_e(a_fa), .o_forward_b_e(a_fb),
      .o_stall_f(a_st[4]), .o_stall_d(a_st[3]), .o_stall_e(a_st[2]),
      .o_stall_m(a_st[1]), .o_stall_w(a_st[0]),
      .o_flush_d(a_fl[1]), .o_flush_e(a_fl[0]),
      .o_mem_timeout(a_tmo), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
   );

   hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(15), .WAIT_W(4), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst),
      .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e), .i_rd_e(rd_e),
      .i_reg_write_e(rwe), .i_mem_read_e(mre), .i_pc_src_e(pcsrc),
      .i_rd_m(rd_m), .i_reg_write_m(rwm), .i_dmem_req_m(req), .i_dmem_ready_m(rdy),
      .i_rd_w(rd_w), .i_reg_write_w(rww),
      .o_forward_a_e(b_fa), .o_forward_b_e(b_fb),
      .o_stall_f(b_st[4]), .o_stall_d(b_st[3]), .o_stall_e(b_st[2]),
      .o_stall_m(b_st[1]), .o_stall_w(b_st[0]),
      .o_flush_d(b_fl[1]), .o_flush_e(b_fl[0]),
      .o_mem_timeout(b_tmo), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit hit(logic [4:0] a, logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   function automatic bit frozen();
      return req && !rdy;
   endfunction

   // d=0 is the forwarding instance, d=1 the stall-only instance.
   function automatic logic [1:0] fsel(int d, logic [4:0] rs);
      if (rst || d != 0) return 2'b00;
      if (rwm && hit(rs, rd_m)) return 2'b10;
      if (rww && hit(rs, rd_w)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit bubble(int d);
      bit eh = hit(rd_e, rs1_d) || hit(rd_e, rs2_d);
      bit mh = hit(rd_m, rs1_d) || hit(rd_m, rs2_d);
      if (d == 0) return mre && rwe && eh;
      return (rwe && eh) || (rwm && mh);
   endfunction

   // Stall vector ordered {F,D,E,M,W}.
   function automatic logic [4:0] exp_stall(int d);
      if (rst) return 5'b00000;
      if (frozen()) return 5'b11111;
      if (pcsrc) return 5'b00000;
      if (bubble(d)) return 5'b11000;
      return 5'b00000;
   endfunction

   // Flush vector ordered {D,E}.
   function automatic logic [1:0] exp_flush(int d);
      if (rst || frozen()) return 2'b00;
      if (pcsrc) return 2'b11;
      if (bubble(d)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         scnt[d] = 0; fcnt[d] = 0; frun[d] = 0; tmo[d] = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string ph);
      check({ph, ".A.fwdA"}, 32'(a_fa), 32'(fsel(0, rs1_e)));
      check({ph, ".A.fwdB"}, 32'(a_fb), 32'(fsel(0, rs2_e)));
      check({ph, ".B.fwdA"}, 32'(b_fa), 32'(fsel(1, rs1_e)));
      check({ph, ".B.fwdB"}, 32'(b_fb), 32'(fsel(1, rs2_e)));
      check({ph, ".A.stall"}, 32'(a_st), 32'(exp_stall(0)));
      check({ph, ".B.stall"}, 32'(b_st), 32'(exp_stall(1)));
      check({ph, ".A.flush"}, 32'(a_fl), 32'(exp_flush(0)));
      check({ph, ".B.flush"}, 32'(b_fl), 32'(exp_flush(1)));
      check({ph, ".A.tmo"}, 32'(a_tmo), 32'(tmo[0]));
      check({ph, ".B.tmo"}, 32'(b_tmo), 32'(tmo[1]));
      check({ph, ".A.scnt"}, 32'(a_sc), 32'(scnt[0]));
      check({ph, ".B.scnt"}, 32'(b_sc), 32'(scnt[1]));
      check({ph, ".A.fcnt"}, 32'(a_fc), 32'(fcnt[0]));
      check({ph, ".B.fcnt"}, 32'(b_fc), 32'(fcnt[1]));
   endtask

   // One clock: check outputs for current inputs, then advance model across the edge.
   task automatic cycle(string ph);
      logic [4:0] s[2];
      bit fz, rd;
      #1;
      check_all(ph);
      for (int d = 0; d < 2; d++) s[d] = exp_stall(d);
      fz = frozen();
      rd = pcsrc && !fz;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (s[d][4] && scnt[d] < cmax[d]) scnt[d]++;
            if (rd && fcnt[d] < cmax[d]) fcnt[d]++;
            frun[d] = fz ? frun[d] + 1 : 0;
            if (frun[d] >= mt[d]) tmo[d] = 1;
         end
      end
      #1;
   endtask

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      rwe = 0; mre = 0; pcsrc = 0; rwm = 0; req = 0; rdy = 1; rww = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      rd_m = 5; rwm = 1; rs1_e = 5; req = 1; rdy = 0; pcsrc = 1;
      #1;
      check_all("reset");
      idle();
      #1 rst = 1'b0;

      // Forwarding priority: M over W, then W, then x0 never forwards.
      rd_m = 5; rwm = 1; rd_w = 5; rww = 1; rs1_e = 5;
      #1 check("fwd.m", 32'(a_fa), 32'd2);
      cycle("fwd_m");
      rwm = 0;
      #1 check("fwd.w", 32'(a_fa), 32'd1);
      cycle("fwd_w");
      rs1_e = 0; rd_m = 0; rd_w = 0; rwm = 1; rww = 1;
      cycle("fwd_x0");
      idle();

      // Load-use: one bubble, then load in M forwards on B operand.
      mre = 1; rwe = 1; rd_e = 7; rs2_d = 7;
      cycle("lu");
      idle();
      rd_m = 7; rwm = 1; rs2_e = 7;
      #1 check("lu.fwdB", 32'(a_fb), 32'd2);
      check("lu.scnt", 32'(a_sc), 32'd1);
      cycle("lu_next");
      idle();
      // ALU producer: only the stall-only instance bubbles.
      rwe = 1; rd_e = 7; rs1_d = 7;
      cycle("alu_raw");
      idle();
      rwm = 1; rd_m = 9; rs2_d = 9;
      cycle("m_raw");
      idle();

      // Redirect alone, then redirect coinciding with load-use.
      pcsrc = 1;
      cycle("redir");
      check("redir.fcnt", 32'(a_fc), 32'd1);
      mre = 1; rwe = 1; rd_e = 3; rs1_d = 3;
      cycle("redir_lu");
      idle();

      // Freeze for 3 cycles with pending redirect, then release.
      req = 1; rdy = 0; pcsrc = 1;
      repeat (3) cycle("frz_redir");
      rdy = 1;
      #1 check("frz.rel.flush", 32'(a_fl), 32'd3);
      cycle("frz_release");
      idle();

      // Timeout on A: rises after 4th frozen edge, stays after ready.
      req = 1; rdy = 0;
      repeat (3) cycle("tmo_pre");
      check("tmo.before", 32'(a_tmo), 32'd0);
      cycle("tmo_edge4");
      check("tmo.after", 32'(a_tmo), 32'd1);
      repeat (2) cycle("tmo_hold");
      rdy = 1;
      repeat (2) cycle("tmo_sticky");

      // Saturation: 20 freeze cycles drive A's 4-bit stall counter to all-ones.
      rdy = 0;
      repeat (20) cycle("sat");
      check("sat.scnt", 32'(a_sc), 32'd15);
      idle();

      // Random traffic with a small register pool to provoke matches.
      for (int i = 0; i < 400; i++) begin
         rs1_d = 5'($urandom_range(0, 6)); rs2_d = 5'($urandom_range(0, 6));
         rs1_e = 5'($urandom_range(0, 6)); rs2_e = 5'($urandom_range(0, 6));
         rd_e  = 5'($urandom_range(0, 6)); rd_m  = 5'($urandom_range(0, 6));
         rd_w  = 5'($urandom_range(0, 6));
         rwe = 1'($urandom_range(0, 1)); mre = 1'($urandom_range(0, 1));
         rwm = 1'($urandom_range(0, 1)); rww = 1'($urandom_range(0, 1));
         pcsrc = ($urandom_range(0, 3) == 0);
         req = 1'($urandom_range(0, 1)); rdy = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end
      idle();

      // Reset asserted mid-freeze clears everything at once.
      req = 1; rdy = 0; pcsrc = 1;
      repeat (3) cycle("pre_rst");
      #3 rst = 1'b1;
      model_reset();
      #1 check_all("rst_async");
      check("rst.stall", 32'(a_st), 32'd0);
      cycle("rst_hold");
      rst = 1'b0;
      repeat (2) cycle("post_rst");
      check("post_rst.tmo", 32'(a_tmo), 32'd0);
      idle();
      cycle("end");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
